// File: rtl/btn_event_gen_pkg.sv
// ----------------------------------------------------------------------------
// btn_event_gen_pkg
//   Shared definitions for the push-button event generator:
//     - classifier FSM state encoding
//     - bit offsets of each event group in the 20-bit GPIO word read by
//       software (four buttons per group, one bit per button)
//     - counter width helper used by the debounce and hold counters
// ----------------------------------------------------------------------------
package btn_event_gen_pkg;

   typedef enum logic [1:0] {
      BTN_ST_REL   = 2'd0,
      BTN_ST_SHORT = 2'd1,
      BTN_ST_LONG  = 2'd2
   } btn_state_t;

   // GPIO word layout: each field is 4 bits wide, one bit per button instance.
   localparam int BTN_GPIO_DOWN = 0;
   localparam int BTN_GPIO_UP   = 4;
   localparam int BTN_GPIO_SHRT = 8;
   localparam int BTN_GPIO_LONG = 12;
   localparam int BTN_GPIO_IMM  = 16;
   localparam int BTN_GPIO_W    = 20;

   // Width of a counter that must be able to hold the value n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
//   Polarity normalisation, 2-FF synchroniser and debounce counter for one
//   raw push-button pin. The output level is 1 = pressed.
//
// Ports
//   clk     in  1  system clock
//   rst     in  1  synchronous, active-high reset
//   btn_in  in  1  raw, asynchronous, bouncing button pin
//   stable  out 1  debounced level (1 = pressed), registered
// ----------------------------------------------------------------------------
module btn_debounce
   import btn_event_gen_pkg::*;
#(
   parameter bit BTN_ACTIVE_LOW = 1'b1,
   parameter int DEBOUNCE_CYC   = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic stable
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             pin_lvl;
   logic [1:0]       sync_ff;
   logic             sync_out;
   logic [CNT_W-1:0] cnt;

   // Normalise polarity so everything downstream sees 1 = pressed.
   assign pin_lvl  = btn_in ^ BTN_ACTIVE_LOW;
   assign sync_out = sync_ff[1];

   // Reset loads "released" so a button held through reset is seen as a
   // fresh press once reset drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], pin_lvl};
      end
   end

   // A new level is accepted only after DEBOUNCE_CYC consecutive cycles of
   // disagreement; any return to the accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync_out == stable) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= sync_out;
      end else begin
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/btn_event_gen.sv
// ----------------------------------------------------------------------------
// btn_event_gen
//   Per-button event generator. Debounces one raw button pin and classifies
//   each press into single-cycle pulses (down, up, short, long) plus a
//   registered debounced level.
//
// Ports
//   clk       in  1  system clock
//   rst       in  1  synchronous, active-high reset
//   btn_in    in  1  raw button pin (asynchronous, bouncing)
//   btn_down  out 1  1-clk pulse: debounced press accepted
//   btn_up    out 1  1-clk pulse: debounced release accepted
//   btn_shrt  out 1  1-clk pulse on release of a short press (with btn_up)
//   btn_long  out 1  1-clk pulse when the hold reaches LONG_CYC cycles
//   btn_imm   out 1  debounced pressed level (1 = pressed)
// ----------------------------------------------------------------------------
module btn_event_gen
   import btn_event_gen_pkg::*;
#(
   parameter bit BTN_ACTIVE_LOW = 1'b1,
   parameter int DEBOUNCE_CYC   = 1_000_000,
   parameter int LONG_CYC       = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_down,
   output logic btn_up,
   output logic btn_shrt,
   output logic btn_long,
   output logic btn_imm
);

   localparam int                HOLD_W    = cnt_width(LONG_CYC);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

   logic              stable;
   btn_state_t        state;
   logic [HOLD_W-1:0] hold_cnt;

   btn_debounce #(
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYC   (DEBOUNCE_CYC)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .stable (stable)
   );

   // Classifier. hold_cnt counts cycles since btn_down; it stops at
   // LONG_CYC-1 so it can never wrap. In SHORT the release test comes
   // first, so a release coinciding with the long threshold is reported
   // as a short press and btn_long is suppressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BTN_ST_REL;
         hold_cnt <= '0;
         btn_down <= 1'b0;
         btn_up   <= 1'b0;
         btn_shrt <= 1'b0;
         btn_long <= 1'b0;
         btn_imm  <= 1'b0;
      end else begin
         btn_down <= 1'b0;
         btn_up   <= 1'b0;
         btn_shrt <= 1'b0;
         btn_long <= 1'b0;
         btn_imm  <= stable;
         case (state)
            BTN_ST_REL: begin
               if (stable) begin
                  btn_down <= 1'b1;
                  hold_cnt <= '0;
                  state    <= BTN_ST_SHORT;
               end
            end
            BTN_ST_SHORT: begin
               if (!stable) begin
                  btn_up   <= 1'b1;
                  btn_shrt <= 1'b1;
                  state    <= BTN_ST_REL;
               end else if (hold_cnt == HOLD_LAST) begin
                  btn_long <= 1'b1;
                  state    <= BTN_ST_LONG;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            BTN_ST_LONG: begin
               if (!stable) begin
                  btn_up <= 1'b1;
                  state  <= BTN_ST_REL;
               end
            end
            default: begin
               state <= BTN_ST_REL;
            end
         endcase
      end
   end

endmodule
